stream_demux1to2: RTL and testbench
===================================

Name: stream_demux1to2

Overview:
- 1-to-2 valid/ready stream demultiplexer: the routing counterpart of the team's 2:1 select mux.
- Steers an input packet stream to one of two output streams, chosen by `sel` at the first beat of each packet.
- The selection is locked until the beat carrying `in_last` is accepted.
- Each output has a one-entry register slice, so all outputs are registered. Used ahead of dual-path datapaths that later recombine through the 2:1 mux.

Parameters:
- WIDTH, 8, data width in bits of every data port.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  WIDTH  input beat payload
- in_valid  input  1  input beat present
- in_last  input  1  final beat of packet
- in_ready  output  1  input beat accepted this cycle when high together with in_valid
- sel  input  1  destination for a new packet: 0 -> out0, 1 -> out1; sampled only at the first beat
- out0_data  output  WIDTH  output 0 payload
- out0_valid  output  1  output 0 beat present
- out0_last  output  1  output 0 end of packet
- out0_ready  input  1  output 0 consumer ready
- out1_data  output  WIDTH  output 1 payload
- out1_valid  output  1  output 1 beat present
- out1_last  output  1  output 1 end of packet
- out1_ready  input  1  output 1 consumer ready
- busy  output  1  packet in progress (route locked)
- cur_sel  output  1  locked destination; valid while busy=1

Behaviour:
- Reset (async assert, sync deassert by the user):
  - state=IDLE; busy=0; cur_sel=0.
  - outN_valid=0, outN_data=0, outN_last=0.
  - Any beats held in the slices and any partial packet are dropped.
- FSM states:
  - IDLE: target = sel (combinational).
  - ROUTE: target = cur_sel; sel is ignored.
- Transitions:
  - IDLE, beat accepted with in_last=0 -> ROUTE; cur_sel <= sel.
  - IDLE, beat accepted with in_last=1 -> stay IDLE (single-beat packet; no lock).
  - ROUTE, beat accepted with in_last=1 -> IDLE.
  - Otherwise hold state.
- busy = (state==ROUTE), registered.
- Accept and ready:
  - accept = in_valid & in_ready.
  - in_ready = !outT_valid | outT_ready, where T = target. This is combinational from outT_ready, sel and state; it does not depend on in_valid.
- Output slice N, per clock:
  - If accept and target==N: outN_data <= in_data, outN_last <= in_last, outN_valid <= 1.
  - Else if outN_ready: outN_valid <= 0.
  - Otherwise hold. outN_data and outN_last stay stable while outN_valid=1 and outN_ready=0.
- Latency: 1 cycle from acceptance to outN_valid.
- Throughput: 1 beat/cycle per output when its consumer holds ready=1.
- Non-target output is never loaded. Its slice drains independently, so a held beat on out0 does not block a new packet routed to out1.
- Back-to-back packets: after an in_last accept, the very next cycle samples sel afresh, giving zero bubble.
- sel change mid-packet has no effect on routing.
- in_valid=0 while in ROUTE: hold the lock indefinitely.
- Data on the input is never duplicated or reordered within an output.

Test Plan:
- Reset mid-stream:
  - Stimulus: out0 holding 0xAA with out0_ready=0, state ROUTE; assert rst_n=0 asynchronously.
  - Required: out0_valid=0, out0_data=0, busy=0 immediately, without waiting for a clock.
- Packet to out1:
  - Stimulus: sel=1, beats 0x11, 0x22, 0x33 (last on 0x33), out1_ready=1.
  - Required: out1 shows 0x11/0x22/0x33 on consecutive cycles, each 1 cycle after acceptance; out1_last only with 0x33; out0_valid stays 0; busy=1 from the cycle after 0x11 until the cycle after 0x33.
- sel toggling mid-packet:
  - Stimulus: sel=0 at the first beat 0x40, then sel=1 during beats 0x41 and 0x42 (last on 0x42).
  - Required: all three beats appear on out0; out1_valid stays 0.
- Backpressure:
  - Stimulus: sel=0, out0_ready=0, beats 0x01 and 0x02.
  - Required: 0x01 is captured; in_ready=0 on the next cycle; 0x01 stays stable. When out0_ready=1, 0x01 is consumed and 0x02 is accepted the same cycle.
- Independent drain:
  - Stimulus: single-beat packet 0x5A to out0 with out0_ready=0, then single-beat packet 0xA5 with sel=1 and out1_ready=1 on the next cycle.
  - Required: 0xA5 is accepted with no stall and appears on out1 while out0 still holds 0x5A.
- Back-to-back single-beat packets:
  - Stimulus: in_valid=1, in_last=1 every cycle, sel alternating 0,1,0,1 with data 0x10..0x13; both readys=1.
  - Required: 0x10 and 0x12 appear on out0, 0x11 and 0x13 on out1; in_ready=1 throughout; busy stays 0.

Source files
------------

// File: rtl/stream_demux1to2.sv
// ---------------------------------------------------------------------------
// stream_demux1to2
//
// 1-to-2 valid/ready packet demultiplexer. The first beat of each packet
// samples `sel` to choose a destination. For a multi-beat packet, that route
// stays locked until the beat carrying in_last is accepted. Each output
// stream is driven from its own one-entry register slice, so every output
// is registered. A beat held on one output never stalls traffic routed to
// the other output.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_data/valid/last    input beat stream
//   in_ready              input beat accepted when high with in_valid
//   sel                   destination of a new packet (0 -> out0, 1 -> out1)
//   out0_data/valid/last  output stream 0, with out0_ready from its consumer
//   out1_data/valid/last  output stream 1, with out1_ready from its consumer
//   busy                  multi-beat packet in progress, route locked
//   cur_sel               locked destination, meaningful while busy=1
// ---------------------------------------------------------------------------
module stream_demux1to2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             sel,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  output logic             out0_last,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  output logic             out1_last,
  input  logic             out1_ready,
  output logic             busy,
  output logic             cur_sel
);

  typedef enum logic {
    IDLE  = 1'b0,
    ROUTE = 1'b1
  } state_t;

  state_t state;
  state_t state_next;
  logic   cur_sel_q;
  logic   cur_sel_next;
  logic   target;
  logic   accept;

  // While idle, the live sel picks the destination so that a new packet
  // can start with zero bubble. Once a packet is locked, only the stored
  // route is used.
  always_comb begin
    target = (state == ROUTE) ? cur_sel_q : sel;
  end

  // The input is accepted when the targeted slice is empty or is draining
  // this cycle. The other slice does not affect this decision.
  always_comb begin
    in_ready = target ? (!out1_valid || out1_ready)
                      : (!out0_valid || out0_ready);
    accept   = in_valid && in_ready;
  end

  // Next-state logic for the route lock. A single-beat packet accepted
  // while idle never enters ROUTE, so back-to-back single beats stay
  // unlocked.
  always_comb begin
    state_next   = state;
    cur_sel_next = cur_sel_q;
    unique case (state)
      IDLE: begin
        if (accept && !in_last) begin
          state_next   = ROUTE;
          cur_sel_next = sel;
        end
      end
      ROUTE: begin
        if (accept && in_last) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register and locked destination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_sel_q <= 1'b0;
    end else begin
      state     <= state_next;
      cur_sel_q <= cur_sel_next;
    end
  end

  // busy and cur_sel are taken straight from flops.
  assign busy    = (state == ROUTE);
  assign cur_sel = cur_sel_q;

  // Output slice 0 loads on an accepted beat routed to it. It empties when
  // its consumer takes the beat, and otherwise holds the beat stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_valid <= 1'b0;
      out0_data  <= '0;
      out0_last  <= 1'b0;
    end else if (accept && !target) begin
      out0_valid <= 1'b1;
      out0_data  <= in_data;
      out0_last  <= in_last;
    end else if (out0_ready) begin
      out0_valid <= 1'b0;
    end
  end

  // Output slice 1 behaves the same way as slice 0, but loads for target=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1_valid <= 1'b0;
      out1_data  <= '0;
      out1_last  <= 1'b0;
    end else if (accept && target) begin
      out1_valid <= 1'b1;
      out1_data  <= in_data;
      out1_last  <= in_last;
    end else if (out1_ready) begin
      out1_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_demux1to2.sv
// ---------------------------------------------------------------------------
// tb_stream_demux1to2
//
// Directed bench for stream_demux1to2. The driver pushes each accepted beat
// into the queue of its hand-chosen destination. A monitor running on the
// falling edge pops the queue and compares whenever an output handshake is
// about to complete. Direct checks cover reset, in_ready, busy and stability.
// ---------------------------------------------------------------------------
module tb_stream_demux1to2;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       sel;
  logic [7:0] out0_data;
  logic       out0_valid;
  logic       out0_last;
  logic       out0_ready;
  logic [7:0] out1_data;
  logic       out1_valid;
  logic       out1_last;
  logic       out1_ready;
  logic       busy;
  logic       cur_sel;

  int n_checks = 0;
  int n_fail   = 0;

  // Each entry is {last, data}.
  logic [8:0] exp_q0[$];
  logic [8:0] exp_q1[$];

  stream_demux1to2 #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .sel        (sel),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_last  (out0_last),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_last  (out1_last),
    .out1_ready (out1_ready),
    .busy       (busy),
    .cur_sel    (cur_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Any hang stops the run with a failure line.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and wait, with a bound, for the DUT to accept it.
  // The beat is queued for the destination chosen by the caller. in_valid
  // stays high afterwards so that consecutive calls form a continuous stream.
  task automatic apply_stimulus(input logic [7:0] d, input logic l, input logic s,
                                input logic dest, output int stalls);
    stalls   = 0;
    in_data  = d;
    in_last  = l;
    sel      = s;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && stalls < 50) begin
      @(negedge clk);
      stalls++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: actual=stalled required=accepted data=0x%0h", d);
    end else if (dest) begin
      exp_q1.push_back({l, d});
    end else begin
      exp_q0.push_back({l, d});
    end
    tick();
  endtask

  task automatic drop_valid();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Scoreboard monitor: an output handshake completes on the next rising
  // edge, so the beat is compared on the falling edge before it.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out0_valid && out0_ready) begin
        if (exp_q0.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL out0_unexpected: actual=0x%0h required=none", out0_data);
        end else begin
          e = exp_q0.pop_front();
          check_output("out0_data", {24'd0, out0_data}, {24'd0, e[7:0]});
          check_output("out0_last", {31'd0, out0_last}, {31'd0, e[8]});
        end
      end
      if (rst_n && out1_valid && out1_ready) begin
        if (exp_q1.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL out1_unexpected: actual=0x%0h required=none", out1_data);
        end else begin
          e = exp_q1.pop_front();
          check_output("out1_data", {24'd0, out1_data}, {24'd0, e[7:0]});
          check_output("out1_last", {31'd0, out1_last}, {31'd0, e[8]});
        end
      end
    end
  end

  initial begin
    int st;
    rst_n      = 1'b0;
    in_data    = '0;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    sel        = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    tick();
    tick();
    check_output("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
    check_output("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
    check_output("rst_out0_data", {24'd0, out0_data}, 32'd0);
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_cur_sel", {31'd0, cur_sel}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a packet while out0 holds a beat.
    apply_stimulus(8'hAA, 1'b0, 1'b0, 1'b0, st);
    drop_valid();
    check_output("mid_busy", {31'd0, busy}, 32'd1);
    check_output("mid_out0_data", {24'd0, out0_data}, 32'hAA);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("arst_out0_valid", {31'd0, out0_valid}, 32'd0);
    check_output("arst_out0_data", {24'd0, out0_data}, 32'd0);
    check_output("arst_busy", {31'd0, busy}, 32'd0);
    exp_q0.delete();
    exp_q1.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Three-beat packet to out1.
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    apply_stimulus(8'h11, 1'b0, 1'b1, 1'b1, st);
    check_output("p1_out1_valid", {31'd0, out1_valid}, 32'd1);
    check_output("p1_busy_first", {31'd0, busy}, 32'd1);
    check_output("p1_cur_sel", {31'd0, cur_sel}, 32'd1);
    check_output("p1_out0_valid", {31'd0, out0_valid}, 32'd0);
    apply_stimulus(8'h22, 1'b0, 1'b1, 1'b1, st);
    check_output("p1_busy_mid", {31'd0, busy}, 32'd1);
    check_output("p1_out0_valid2", {31'd0, out0_valid}, 32'd0);
    apply_stimulus(8'h33, 1'b1, 1'b1, 1'b1, st);
    check_output("p1_busy_end", {31'd0, busy}, 32'd0);
    check_output("p1_out1_last", {31'd0, out1_last}, 32'd1);
    drop_valid();
    tick();
    check_output("p1_out1_drained", {31'd0, out1_valid}, 32'd0);

    // sel toggles mid-packet; the route stays on out0.
    apply_stimulus(8'h40, 1'b0, 1'b0, 1'b0, st);
    apply_stimulus(8'h41, 1'b0, 1'b1, 1'b0, st);
    check_output("tog_cur_sel", {31'd0, cur_sel}, 32'd0);
    check_output("tog_out1_valid", {31'd0, out1_valid}, 32'd0);
    apply_stimulus(8'h42, 1'b1, 1'b1, 1'b0, st);
    check_output("tog_out1_valid2", {31'd0, out1_valid}, 32'd0);
    drop_valid();
    tick();

    // Backpressure on out0.
    out0_ready = 1'b0;
    apply_stimulus(8'h01, 1'b0, 1'b0, 1'b0, st);
    in_data = 8'h02;
    in_last = 1'b1;
    @(negedge clk);
    check_output("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check_output("bp_hold_data", {24'd0, out0_data}, 32'h01);
    tick();
    @(negedge clk);
    check_output("bp_hold_data2", {24'd0, out0_data}, 32'h01);
    check_output("bp_hold_valid", {31'd0, out0_valid}, 32'd1);
    tick();
    out0_ready = 1'b1;
    apply_stimulus(8'h02, 1'b1, 1'b0, 1'b0, st);
    check_output("bp_no_stall", st, 32'd0);
    check_output("bp_out0_data", {24'd0, out0_data}, 32'h02);
    drop_valid();
    tick();

    // out0 holds 0x5A while a packet for out1 goes through unblocked.
    out0_ready = 1'b0;
    out1_ready = 1'b1;
    apply_stimulus(8'h5A, 1'b1, 1'b0, 1'b0, st);
    apply_stimulus(8'hA5, 1'b1, 1'b1, 1'b1, st);
    check_output("ind_no_stall", st, 32'd0);
    check_output("ind_out1_data", {24'd0, out1_data}, 32'hA5);
    check_output("ind_out0_valid", {31'd0, out0_valid}, 32'd1);
    check_output("ind_out0_data", {24'd0, out0_data}, 32'h5A);
    drop_valid();
    tick();
    out0_ready = 1'b1;
    tick();
    tick();

    // Back-to-back single-beat packets alternating between the outputs.
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(8'h10 + 8'(i), 1'b1, 1'(i % 2), 1'(i % 2), st);
      check_output("b2b_no_stall", st, 32'd0);
      check_output("b2b_busy", {31'd0, busy}, 32'd0);
    end
    drop_valid();
    tick();
    tick();

    check_output("sb_q0_empty", exp_q0.size(), 32'd0);
    check_output("sb_q1_empty", exp_q1.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
